// File: rtl/posterise_pkg.sv
// Shared level, mode and state encodings for the posterise sequencer.
package posterise_pkg;

    localparam int unsigned LVL_W = 3;

    localparam logic [LVL_W-1:0] LVL_BYPASS = 3'd0;
    localparam logic [LVL_W-1:0] LVL_1      = 3'd1;
    localparam logic [LVL_W-1:0] LVL_2      = 3'd2;
    localparam logic [LVL_W-1:0] LVL_3      = 3'd3;
    localparam logic [LVL_W-1:0] LVL_4      = 3'd4;
    localparam logic [LVL_W-1:0] LVL_5      = 3'd5;

    // Code 3 is RANDOM when POSTERISE_SEQ_RANDOM_EN is defined.
    typedef enum logic [1:0] {
        SEQ_MANUAL    = 2'd0,
        SEQ_RAMP_UP   = 2'd1,
        SEQ_RAMP_DOWN = 2'd2,
        SEQ_PING_PONG = 2'd3
    } seq_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] x,
                                                  input logic [LVL_W-1:0] lo_b,
                                                  input logic [LVL_W-1:0] hi_b);
        logic [LVL_W-1:0] r;
        r = x;
        if (x < lo_b) r = lo_b;
        if (x > hi_b) r = hi_b;
        return r;
    endfunction

endpackage

// File: rtl/posterise_sequencer_vsync_edge_det.sv
// Two-flop vsync register with a rising-edge pulse (combinational, one clk wide).
module vsync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic rise_c
);

    logic sync_q;
    logic sync_q2;

    // Reset to "high" so a sync held high through reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q  <= sync_in;
            sync_q2 <= sync_q;
        end
    end

    assign rise_c = sync_q & ~sync_q2;

endmodule

// File: rtl/posterise_sequencer.sv
// Frame-synchronous posterise level sequencer (manual / ramp / ping-pong sweep).
// Define POSTERISE_SEQ_RANDOM_EN to turn seq_mode 3 into an LFSR-driven random level.
module posterise_sequencer
    import posterise_pkg::*;
#(
    parameter int unsigned LVL_MIN = 1,
    parameter int unsigned LVL_MAX = 5,
    parameter int unsigned HOLD_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync_in,
    input  logic              seq_en,
    input  logic [1:0]        seq_mode,
    input  logic [2:0]        manual_level,
    input  logic [2:0]        lo_level,
    input  logic [2:0]        hi_level,
    input  logic [HOLD_W-1:0] hold_frames,
    output logic [2:0]        mode_out,
    output logic              step_pulse,
    output logic              frame_tick
);

    localparam logic [LVL_W-1:0] MIN_L = LVL_W'(LVL_MIN);
    localparam logic [LVL_W-1:0] MAX_L = LVL_W'(LVL_MAX);
    localparam int unsigned      CNT_W = HOLD_W + 1;

    logic rise_c;

    vsync_edge_det u_vsync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (vsync_in),
        .rise_c  (rise_c)
    );

    state_e            state_q,  state_d;
    seq_mode_e         mode_q,   mode_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [HOLD_W-1:0] cnt_q,    cnt_d;
    logic              dir_up_q, dir_up_d;
    logic              step_q,   step_d;
    logic              tick_q,   tick_d;

    seq_mode_e         cfg_mode_c;
    logic [LVL_W-1:0]  lo_c, hi_raw_c, hi_c, man_c, start_c, adv_c;
    logic [CNT_W-1:0]  hold_c;
    logic              expire_c, adv_up_c;

`ifdef POSTERISE_SEQ_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR, taps 16,14,13,11, stepped once per frame.
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick_q) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    // Effective configuration after clamping.
    always_comb begin
        cfg_mode_c = seq_mode_e'(seq_mode);
        lo_c       = clamp_lvl(lo_level, MIN_L, MAX_L);
        hi_raw_c   = clamp_lvl(hi_level, MIN_L, MAX_L);
        hi_c       = (lo_c > hi_raw_c) ? lo_c : hi_raw_c;
        man_c      = clamp_lvl(manual_level, MIN_L, MAX_L);
        hold_c     = (hold_frames == '0) ? CNT_W'(1) : CNT_W'(hold_frames);
        expire_c   = (CNT_W'(cnt_q) + CNT_W'(1)) >= hold_c;
        case (cfg_mode_c)
            SEQ_MANUAL:    start_c = man_c;
            SEQ_RAMP_DOWN: start_c = hi_c;
            default:       start_c = lo_c;
        endcase
    end

    // Next sweep level once the hold period expires.
    always_comb begin
        adv_c    = level_q;
        adv_up_c = dir_up_q;
        case (mode_q)
            SEQ_RAMP_UP:   adv_c = (level_q >= hi_c) ? lo_c : level_q + 3'd1;
            SEQ_RAMP_DOWN: adv_c = (level_q <= lo_c) ? hi_c : level_q - 3'd1;
            SEQ_PING_PONG: begin
`ifdef POSTERISE_SEQ_RANDOM_EN
                adv_c = lo_c + LVL_W'(lfsr_q % 16'(hi_c - lo_c + 3'd1));
`else
                if (dir_up_q) begin
                    if (level_q < hi_c) begin
                        adv_c = level_q + 3'd1;
                    end else if (level_q > lo_c) begin
                        adv_c    = level_q - 3'd1;
                        adv_up_c = 1'b0;
                    end
                end else begin
                    if (level_q > lo_c) begin
                        adv_c = level_q - 3'd1;
                    end else if (level_q < hi_c) begin
                        adv_c    = level_q + 3'd1;
                        adv_up_c = 1'b1;
                    end
                end
`endif
            end
            default: adv_c = level_q;
        endcase
    end

    // Frame-edge state update.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        step_d   = 1'b0;
        tick_d   = rise_c;
        if (tick_q) begin
            if (!seq_en) begin
                state_d  = ST_IDLE;
                level_d  = LVL_BYPASS;
                cnt_d    = '0;
                dir_up_d = 1'b1;
            end else if (state_q == ST_IDLE || cfg_mode_c != mode_q) begin
                state_d  = ST_RUN;
                mode_d   = cfg_mode_c;
                level_d  = start_c;
                cnt_d    = '0;
                dir_up_d = 1'b1;
            end else if (mode_q == SEQ_MANUAL) begin
                level_d = man_c;
            end else if (level_q < lo_c) begin
                level_d = lo_c;
                cnt_d   = '0;
            end else if (level_q > hi_c) begin
                level_d = hi_c;
                cnt_d   = '0;
            end else if (expire_c) begin
                level_d  = adv_c;
                dir_up_d = adv_up_c;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + HOLD_W'(1);
            end
            step_d = (level_d != level_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= SEQ_MANUAL;
            level_q  <= LVL_BYPASS;
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
            step_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
        end
    end

    assign mode_out   = level_q;
    assign step_pulse = step_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_posterise_sequencer.sv
// Randomized self-checking bench for posterise_sequencer against a frame-level reference model.
`timescale 1ns/1ps
module tb_posterise_sequencer;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       vsync_in     = 1'b0;
    logic       seq_en       = 1'b0;
    logic [1:0] seq_mode     = 2'd0;
    logic [2:0] manual_level = 3'd0;
    logic [2:0] lo_level     = 3'd1;
    logic [2:0] hi_level     = 3'd5;
    logic [7:0] hold_frames  = 8'd0;
    logic [2:0] mode_out;
    logic       step_pulse;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sweep position as a step index k over the pattern.
    bit m_active = 1'b0;
    int m_mode   = 0;
    int m_k      = 0;
    int m_cnt    = 0;
    int m_level  = 0;

    int exp_ramp[8] = '{2, 2, 3, 3, 4, 4, 2, 2};
    int exp_pp[7]   = '{1, 2, 3, 2, 1, 2, 3};

    always #5 clk = ~clk;

    posterise_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync_in     (vsync_in),
        .seq_en       (seq_en),
        .seq_mode     (seq_mode),
        .manual_level (manual_level),
        .lo_level     (lo_level),
        .hi_level     (hi_level),
        .hold_frames  (hold_frames),
        .mode_out     (mode_out),
        .step_pulse   (step_pulse),
        .frame_tick   (frame_tick)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int x);
        if (x < 1) return 1;
        if (x > 5) return 5;
        return x;
    endfunction

    function automatic int model_level();
        int lo, hi, n, p;
        if (!m_active) return 0;
        lo = clampi(int'(lo_level));
        hi = clampi(int'(hi_level));
        if (hi < lo) hi = lo;
        n = hi - lo + 1;
        case (m_mode)
            0: return clampi(int'(manual_level));
            1: return lo + (m_k % n);
            2: return hi - (m_k % n);
            default: begin
                if (n == 1) return lo;
                p = m_k % (2 * (n - 1));
                return (p < n) ? lo + p : hi - (p - (n - 1));
            end
        endcase
    endfunction

    task automatic model_frame();
        int hold;
        hold = (hold_frames == 8'd0) ? 1 : int'(hold_frames);
        if (!seq_en) begin
            m_active = 1'b0;
        end else if (!m_active || int'(seq_mode) != m_mode) begin
            m_active = 1'b1;
            m_mode   = int'(seq_mode);
            m_k      = 0;
            m_cnt    = 0;
        end else if (m_mode != 0) begin
            if (m_cnt + 1 >= hold) begin
                m_k++;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One vsync pulse; checks tick timing, level latency and step_pulse.
    task automatic frame(input string tag);
        int old_lvl, new_lvl;
        old_lvl = m_level;
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        check_eq({tag, ".tick_early"}, int'(frame_tick), 0);
        @(negedge clk);
        check_eq({tag, ".tick"}, int'(frame_tick), 1);
        check_eq({tag, ".pre"}, int'(mode_out), old_lvl);
        model_frame();
        new_lvl = model_level();
        m_level = new_lvl;
        @(negedge clk);
        check_eq({tag, ".level"}, int'(mode_out), new_lvl);
        check_eq({tag, ".step"}, int'(step_pulse), int'(new_lvl != old_lvl));
        vsync_in = 1'b0;
        @(negedge clk);
        check_eq({tag, ".step_end"}, int'(step_pulse), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst.mode", int'(mode_out), 0);
        check_eq("rst.step", int'(step_pulse), 0);
        check_eq("rst.tick", int'(frame_tick), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        seq_en = 1'b1; seq_mode = 2'd0; manual_level = 3'd3;
        frame("manual3");
        check_eq("manual3.const", int'(mode_out), 3);

        seq_mode = 2'd1; lo_level = 3'd2; hi_level = 3'd4; hold_frames = 8'd2;
        for (int i = 0; i < 8; i++) begin
            frame("ramp_up");
            check_eq("ramp_up.seq", int'(mode_out), exp_ramp[i]);
        end

        seq_mode = 2'd3; lo_level = 3'd1; hi_level = 3'd3; hold_frames = 8'd0;
        for (int i = 0; i < 7; i++) begin
            frame("ping_pong");
            check_eq("ping_pong.seq", int'(mode_out), exp_pp[i]);
        end

        seq_mode = 2'd0; manual_level = 3'd2;
        frame("manual2");
        manual_level = 3'd5;
        repeat (10) @(negedge clk);
        check_eq("midframe.hold", int'(mode_out), 2);
        frame("manual5");
        check_eq("manual5.const", int'(mode_out), 5);

        manual_level = 3'd0;
        frame("clamp_lo");
        check_eq("clamp_lo.const", int'(mode_out), 1);
        manual_level = 3'd7;
        frame("clamp_hi");
        check_eq("clamp_hi.const", int'(mode_out), 5);

        seq_mode = 2'd1; lo_level = 3'd4; hi_level = 3'd2; hold_frames = 8'd0;
        for (int i = 0; i < 4; i++) begin
            frame("lock");
            check_eq("lock.const", int'(mode_out), 4);
        end

        seq_mode = 2'd2; lo_level = 3'd1; hi_level = 3'd5; hold_frames = 8'd1;
        repeat (3) frame("ramp_down");
        seq_en = 1'b0;
        frame("disable");
        check_eq("disable.const", int'(mode_out), 0);
        seq_en = 1'b1;
        frame("reenable");

        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.mode", int'(mode_out), 0);
        check_eq("midrst.step", int'(step_pulse), 0);
        m_active = 1'b0; m_level = 0;
        vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("postrst.tick", int'(frame_tick), 0);
            check_eq("postrst.step", int'(step_pulse), 0);
        end
        check_eq("postrst.mode", int'(mode_out), 0);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        frame("fresh_edge");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) seq_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) hold_frames = 8'($urandom_range(0, 3));
            manual_level = 3'($urandom_range(0, 7));
            seq_en = ($urandom_range(0, 7) != 0);
            if (!m_active) begin
                lo_level = 3'($urandom_range(0, 7));
                hi_level = 3'($urandom_range(0, 7));
            end
            frame("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
